// File: rtl/fp_pkg.sv
// Shared COP1 encodings, datapath op codes and issue FSM states for the FP unit.
package fp_pkg;

  localparam logic [5:0] OPC_COP1   = 6'b010001;

  localparam logic [4:0] FMT_ARITH  = 5'b00000;
  localparam logic [4:0] FMT_LWC1   = 5'b00100;
  localparam logic [4:0] FMT_SWC1   = 5'b00101;

  localparam logic [5:0] FUNCT_ADD  = 6'b000000;
  localparam logic [5:0] FUNCT_SUB  = 6'b000001;
  localparam logic [5:0] FUNCT_MUL  = 6'b000010;
  localparam logic [5:0] FUNCT_DIV  = 6'b000011;

  typedef enum logic [1:0] {
    FP_ADD = 2'd0,
    FP_SUB = 2'd1,
    FP_MUL = 2'd2,
    FP_DIV = 2'd3
  } fp_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } fp_state_t;

  // add/sub/mul/div occupy funct 0..3; everything above is unknown.
  function automatic logic is_arith_funct(input logic [5:0] funct);
    return (funct[5:2] == 4'b0000);
  endfunction

endpackage

// File: rtl/fp_issue_ctrl_if.sv
// Decode-stage to FP issue controller bus: instruction fields in, control out.
interface fp_issue_ctrl_if;

  logic       instr_valid;
  logic [5:0] opcode;
  logic [4:0] fmt;
  logic [5:0] fp_funct;
  logic [4:0] ft;
  logic [4:0] fd;
  logic       flush;

  logic       is_fp_op;
  logic       stall;
  logic       fp_start;
  logic [1:0] fp_op;
  logic       fp_write;
  logic [4:0] fp_wr_addr;
  logic       fp_mem_read;
  logic       fp_mem_write;
  logic       illegal_fp;

  modport master (
    output instr_valid, opcode, fmt, fp_funct, ft, fd, flush,
    input  is_fp_op, stall, fp_start, fp_op, fp_write, fp_wr_addr,
           fp_mem_read, fp_mem_write, illegal_fp
  );

  modport slave (
    input  instr_valid, opcode, fmt, fp_funct, ft, fd, flush,
    output is_fp_op, stall, fp_start, fp_op, fp_write, fp_wr_addr,
           fp_mem_read, fp_mem_write, illegal_fp
  );

endinterface

// File: rtl/fp_lat_counter.sv
// Loadable saturating down-counter used to time multi-cycle FP operations.
module fp_lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] value_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Load has priority; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign value_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/fp_issue_ctrl.sv
// COP1 issue controller: decodes FP instructions, sequences multi-cycle
// arithmetic through IDLE/EXEC/WB, and pulses single-cycle lwc1/swc1.
module fp_issue_ctrl
  import fp_pkg::*;
#(
  parameter int ADD_LAT = 3,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_issue_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);

  fp_state_t  state_q, state_d;
  fp_op_t     op_q, op_d;
  logic       stall_q, stall_d;
  logic       start_q, start_d;
  logic       write_q, write_d;
  logic [4:0] addr_q, addr_d;
  logic       mrd_q, mrd_d;
  logic       mwr_q, mwr_d;
  logic       ill_q, ill_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;

  logic dec_arith, dec_lwc1, dec_swc1, offer, mem_pend;

  assign bus.is_fp_op = bus.instr_valid && (bus.opcode == OPC_COP1);
  assign dec_arith    = (bus.fmt == FMT_ARITH) && is_arith_funct(bus.fp_funct);
  assign dec_lwc1     = (bus.fmt == FMT_LWC1);
  assign dec_swc1     = (bus.fmt == FMT_SWC1);
  assign offer        = bus.is_fp_op && !bus.flush;

  // The WB cycle already owns the register-file write port, so a memory op
  // arriving then is held back one more cycle.
  assign mem_pend  = (state_q == ST_WB) && offer && (dec_lwc1 || dec_swc1);
  assign bus.stall = stall_q || mem_pend;

  fp_lat_counter #(.W(CNT_W)) u_lat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .value_o    (cnt_value),
    .zero_o     (cnt_zero)
  );

  // Next state, registered-output values and counter control.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    stall_d      = 1'b0;
    start_d      = 1'b0;
    write_d      = 1'b0;
    mrd_d        = 1'b0;
    mwr_d        = 1'b0;
    ill_d        = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    case (state_q)
      ST_EXEC: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d = ST_WB;
          write_d = 1'b1;
        end else begin
          cnt_dec = (cnt_value != '0);
          stall_d = 1'b1;
        end
      end

      ST_IDLE, ST_WB: begin
        state_d = ST_IDLE;
        if (offer) begin
          if (dec_arith) begin
            state_d  = ST_EXEC;
            start_d  = 1'b1;
            op_d     = fp_op_t'(bus.fp_funct[1:0]);
            addr_d   = bus.fd;
            stall_d  = 1'b1;
            cnt_load = 1'b1;
            case (bus.fp_funct[1:0])
              2'd2:    cnt_load_val = CNT_W'(MUL_LAT - 2);
              2'd3:    cnt_load_val = CNT_W'(DIV_LAT - 2);
              default: cnt_load_val = CNT_W'(ADD_LAT - 2);
            endcase
          end else if (dec_lwc1 && (state_q == ST_IDLE)) begin
            mrd_d   = 1'b1;
            write_d = 1'b1;
            addr_d  = bus.ft;
          end else if (dec_swc1 && (state_q == ST_IDLE)) begin
            mwr_d = 1'b1;
          end else if (!dec_lwc1 && !dec_swc1) begin
            ill_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= FP_ADD;
      addr_q  <= '0;
      stall_q <= 1'b0;
      start_q <= 1'b0;
      write_q <= 1'b0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      stall_q <= stall_d;
      start_q <= start_d;
      write_q <= write_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.fp_start     = start_q;
  assign bus.fp_op        = op_q;
  assign bus.fp_write     = write_q;
  assign bus.fp_wr_addr   = addr_q;
  assign bus.fp_mem_read  = mrd_q;
  assign bus.fp_mem_write = mwr_q;
  assign bus.illegal_fp   = ill_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Scoreboard bench for fp_issue_ctrl: expected output pulses are queued when
// an instruction is accepted and matched as the controller produces them.
module tb_fp_issue_ctrl;

  localparam int ADD_LAT = 3;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 12;

  localparam logic [5:0] COP1 = 6'b010001;

  localparam int K_START = 0;
  localparam int K_WRITE = 1;
  localparam int K_MRD   = 2;
  localparam int K_MWR   = 3;
  localparam int K_ILL   = 4;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_fail;

  ev_t   sbq [5][$];
  string nm  [5] = '{"start", "write", "mrd", "mwr", "ill"};
  logic  mon_fired [5];
  int    mon_val   [5];
  ev_t   mon_e;

  fp_issue_ctrl_if bus ();

  fp_issue_ctrl #(
    .ADD_LAT (ADD_LAT),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int k, input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    sbq[k].push_back(e);
  endtask

  // Expected effects of an instruction accepted at the edge ending cycle t.
  task automatic sb_push(input logic [4:0] f, input logic [5:0] fn,
                         input logic [4:0] ft_, input logic [4:0] fd_,
                         input int t, input bit wb);
    int lat;
    if (f == 5'b00000 && fn < 6'd4) begin
      lat = (fn == 6'd2) ? MUL_LAT : (fn == 6'd3) ? DIV_LAT : ADD_LAT;
      push(K_START, t + 1, int'(fn));
      if (wb) push(K_WRITE, t + lat, int'(fd_));
    end else if (f == 5'b00100) begin
      push(K_MRD, t + 1, int'(ft_));
      push(K_WRITE, t + 1, int'(ft_));
    end else if (f == 5'b00101) begin
      push(K_MWR, t + 1, 0);
    end else begin
      push(K_ILL, t + 1, 0);
    end
  endtask

  // Hold a COP1 instruction until the controller takes it; returns the
  // cycle whose closing edge accepted it.
  task automatic present(input logic [4:0] f, input logic [5:0] fn,
                         input logic [4:0] ft_, input logic [4:0] fd_,
                         output int t_acc);
    bus.instr_valid = 1'b1;
    bus.opcode      = COP1;
    bus.fmt         = f;
    bus.fp_funct    = fn;
    bus.ft          = ft_;
    bus.fd          = fd_;
    bus.flush       = 1'b0;
    t_acc = -1;
    for (int i = 0; i < 100 && t_acc < 0; i++) begin
      #1;
      if (!bus.stall) t_acc = cyc;
      @(posedge clk);
      #1;
    end
    bus.instr_valid = 1'b0;
    if (t_acc < 0) chk("accept_timeout", t_acc, 0);
  endtask

  // Match every output pulse against the head of its queue.
  always @(negedge clk) begin
    mon_fired[K_START] = bus.fp_start;     mon_val[K_START] = int'(bus.fp_op);
    mon_fired[K_WRITE] = bus.fp_write;     mon_val[K_WRITE] = int'(bus.fp_wr_addr);
    mon_fired[K_MRD]   = bus.fp_mem_read;  mon_val[K_MRD]   = int'(bus.fp_wr_addr);
    mon_fired[K_MWR]   = bus.fp_mem_write; mon_val[K_MWR]   = int'(bus.fp_write);
    mon_fired[K_ILL]   = bus.illegal_fp;   mon_val[K_ILL]   = int'({bus.fp_start, bus.fp_write});
    for (int k = 0; k < 5; k++) begin
      while (sbq[k].size() > 0 && sbq[k][0].cyc < cyc) begin
        mon_e = sbq[k].pop_front();
        chk({nm[k], "_missing"}, cyc, mon_e.cyc);
      end
      if (mon_fired[k] === 1'b1) begin
        if (sbq[k].size() == 0) begin
          chk({nm[k], "_unexpected"}, mon_fired[k], 1'b0);
        end else begin
          mon_e = sbq[k].pop_front();
          chk({nm[k], "_cycle"}, cyc, mon_e.cyc);
          chk({nm[k], "_value"}, mon_val[k], mon_e.val);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, bus.stall, 0);
    chk({tag, "_start"}, bus.fp_start, 0);
    chk({tag, "_op"},    bus.fp_op, 0);
    chk({tag, "_write"}, bus.fp_write, 0);
    chk({tag, "_addr"},  bus.fp_wr_addr, 0);
    chk({tag, "_mrd"},   bus.fp_mem_read, 0);
    chk({tag, "_mwr"},   bus.fp_mem_write, 0);
    chk({tag, "_ill"},   bus.illegal_fp, 0);
  endtask

  initial begin
    int t, t2;
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    bus.instr_valid = 1'b0;
    bus.opcode      = '0;
    bus.fmt         = '0;
    bus.fp_funct    = '0;
    bus.ft          = '0;
    bus.fd          = '0;
    bus.flush       = 1'b0;

    #2;
    chk_all_zero("reset");
    chk("reset_is_fp_op", bus.is_fp_op, 0);
    step(3);
    rst_n = 1'b1;
    step(3);

    // is_fp_op is combinational on valid and opcode
    bus.instr_valid = 1'b1;
    bus.opcode      = COP1;
    bus.flush       = 1'b1;
    #1;
    chk("is_fp_op_cop1", bus.is_fp_op, 1);
    bus.opcode = 6'b000000;
    #1;
    chk("is_fp_op_other", bus.is_fp_op, 0);
    step(1);
    bus.instr_valid = 1'b0;
    bus.flush       = 1'b0;
    step(2);

    // add.s f3: stall for L-1 cycles, write in cycle T+L
    present(5'b00000, 6'd0, 5'd0, 5'd3, t);
    sb_push(5'b00000, 6'd0, 5'd0, 5'd3, t, 1'b1);
    chk("add_stall_t1", bus.stall, 1);
    step(1);
    chk("add_stall_t2", bus.stall, 1);
    step(1);
    chk("add_stall_wb", bus.stall, 0);
    step(3);

    // div.s f7, then add.s f2 held under stall and taken in the WB cycle
    present(5'b00000, 6'd3, 5'd0, 5'd7, t);
    sb_push(5'b00000, 6'd3, 5'd0, 5'd7, t, 1'b1);
    present(5'b00000, 6'd0, 5'd0, 5'd2, t2);
    chk("b2b_accept_cycle", t2, t + DIV_LAT);
    sb_push(5'b00000, 6'd0, 5'd0, 5'd2, t2, 1'b1);
    step(ADD_LAT + 2);

    // lwc1 ft=9 then swc1: no stall at any point
    present(5'b00100, 6'd0, 5'd9, 5'd0, t);
    sb_push(5'b00100, 6'd0, 5'd9, 5'd0, t, 1'b1);
    chk("lwc1_stall", bus.stall, 0);
    present(5'b00101, 6'd0, 5'd11, 5'd0, t2);
    chk("swc1_accept_cycle", t2, t + 1);
    sb_push(5'b00101, 6'd0, 5'd11, 5'd0, t2, 1'b1);
    chk("swc1_stall", bus.stall, 0);
    step(3);

    // mul.s flushed in its second EXEC cycle; add.s follows normally
    present(5'b00000, 6'd2, 5'd0, 5'd4, t);
    sb_push(5'b00000, 6'd2, 5'd0, 5'd4, t, 1'b0);
    step(1);
    bus.flush = 1'b1;
    step(1);
    bus.flush = 1'b0;
    chk("flush_exec_stall", bus.stall, 0);
    present(5'b00000, 6'd0, 5'd0, 5'd5, t2);
    chk("post_flush_accept", t2, t + 3);
    sb_push(5'b00000, 6'd0, 5'd0, 5'd5, t2, 1'b1);
    step(ADD_LAT + 2);

    // asynchronous reset in the middle of a div.s
    present(5'b00000, 6'd3, 5'd0, 5'd6, t);
    sb_push(5'b00000, 6'd3, 5'd0, 5'd6, t, 1'b0);
    step(3);
    chk("div_mid_stall", bus.stall, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    step(1);
    rst_n = 1'b1;
    step(DIV_LAT + 3);

    // illegal funct under arith fmt, then illegal fmt
    present(5'b00000, 6'd7, 5'd0, 5'd1, t);
    sb_push(5'b00000, 6'd7, 5'd0, 5'd1, t, 1'b1);
    present(5'b01000, 6'd0, 5'd0, 5'd1, t2);
    chk("ill2_accept_cycle", t2, t + 1);
    sb_push(5'b01000, 6'd0, 5'd0, 5'd1, t2, 1'b1);
    step(3);

    // lwc1 arriving during an add is held past the WB cycle
    present(5'b00000, 6'd1, 5'd0, 5'd1, t);
    sb_push(5'b00000, 6'd1, 5'd0, 5'd1, t, 1'b1);
    present(5'b00100, 6'd0, 5'd12, 5'd0, t2);
    chk("wb_mem_hold_cycle", t2, t + ADD_LAT + 1);
    sb_push(5'b00100, 6'd0, 5'd12, 5'd0, t2, 1'b1);
    step(3);

    // flush in WB still writes
    present(5'b00000, 6'd0, 5'd0, 5'd8, t);
    sb_push(5'b00000, 6'd0, 5'd0, 5'd8, t, 1'b1);
    step(ADD_LAT - 1);
    bus.flush = 1'b1;
    step(1);
    bus.flush = 1'b0;
    chk("flush_wb_stall", bus.stall, 0);
    step(2);

    // flush together with a valid instruction: nothing accepted
    bus.instr_valid = 1'b1;
    bus.opcode      = COP1;
    bus.fmt         = 5'b00000;
    bus.fp_funct    = 6'd0;
    bus.fd          = 5'd10;
    bus.flush       = 1'b1;
    step(1);
    bus.instr_valid = 1'b0;
    bus.flush       = 1'b0;
    chk("flush_vld_stall", bus.stall, 0);
    step(ADD_LAT + 3);

    for (int k = 0; k < 5; k++) chk({nm[k], "_left"}, sbq[k].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_issue_ctrl.md
Name: fp_issue_ctrl

Overview:
Sequential successor to the combinational COP1 decoder. It decodes COP1 instructions and issues add.s, sub.s, mul.s and div.s to the multi-cycle FP datapath. Per-operation latencies are parameterised. It stalls the integer pipeline while an op is in flight, then generates a single-cycle FP register-file write. It also handles lwc1/swc1 as single-cycle memory ops, and supports pipeline flush and illegal-encoding detection.

Parameters:
ADD_LAT, 3, cycles from accept to writeback for add.s/sub.s (2..15)
MUL_LAT, 4, cycles for mul.s (2..15)
DIV_LAT, 12, cycles for div.s (2..63)
CNT_W, $clog2(DIV_LAT+1), latency counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  decode-stage instruction valid; held by the pipeline while stall=1
opcode  in  6  instr[31:26]
fmt  in  5  instr[25:21]
fp_funct  in  6  instr[5:0]
ft  in  5  instr[20:16]
fd  in  5  instr[10:6]
flush  in  1  synchronous kill of the in-flight op
is_fp_op  out  1  combinational: instr_valid && opcode==COP1
stall  out  1  registered; hold upstream pipeline
fp_start  out  1  one-cycle issue pulse to the datapath
fp_op  out  2  datapath op select: 0 add, 1 sub, 2 mul, 3 div; held through EXEC
fp_write  out  1  FP register-file write enable, one cycle
fp_wr_addr  out  5  FP destination register
fp_mem_read  out  1  lwc1 pulse
fp_mem_write  out  1  swc1 pulse
illegal_fp  out  1  one-cycle pulse on unknown COP1 fmt/funct

Behaviour:
- Reset (async assert, sync deassert by design):
  - all registered outputs 0, fp_wr_addr 0, counter 0, state IDLE
  - reset mid-EXEC drops the op; no fp_write is ever produced for it
- Encodings:
  - COP1 = 6'b010001
  - fmt 00000 = arithmetic; fp_funct 000000/000001/000010/000011 = add/sub/mul/div
  - fmt 00100 = lwc1, fmt 00101 = swc1
  - anything else under COP1 is illegal
- Accept: only in IDLE or WB, with instr_valid && is_fp_op && !flush, sampled at edge ending cycle T.
- FSM states IDLE, EXEC, WB:
  - IDLE --legal arith--> EXEC: cycle T+1 fp_start=1, fp_op latched, fd latched, stall=1, counter=L-2
  - EXEC: counter decrements each cycle; when it reaches 0, next state is WB; stall=1 throughout
  - WB (cycle T+L): fp_write=1, fp_wr_addr=latched fd, stall=0
    - new legal arith in WB goes back to EXEC (back-to-back)
    - otherwise go to IDLE
  - L = ADD_LAT (add/sub), MUL_LAT, or DIV_LAT
- lwc1 accepted:
  - cycle T+1: fp_mem_read=1, fp_write=1, fp_wr_addr=ft
  - state returns/stays IDLE; no stall
- swc1 accepted: cycle T+1 fp_mem_write=1; no write; no stall.
- Illegal accepted: cycle T+1 illegal_fp=1; no other effect; state IDLE.
- WB write port conflict: memory ops are never accepted in the WB cycle; the pipeline is stalled one extra cycle (stall=1 combinationally in WB when a memory op is pending). An arith op may be accepted in WB.
- Flush:
  - in EXEC: next cycle IDLE, stall=0, no fp_write
  - in WB: fp_write for that cycle still occurs (already committed)
  - flush with instr_valid in the same cycle: flush wins, nothing accepted
- Instructions presented while stall=1 are ignored; no side effects.
- Counter never wraps; it is loaded only on accept.

Decomposition:
- Shared package fp_pkg:
  - COP1 opcode
  - FMT_ARITH / FMT_LWC1 / FMT_SWC1
  - funct codes
  - fp_op_t 2-bit enum
  - FSM state enum
- One natural sub-module: fp_lat_counter. It is a loadable down-counter, parameter W, with load/value/zero flag, reused by future FP units.

Test Plan:
- add.s f3 issued at cycle 10, ADD_LAT=3 → fp_start at 11 with fp_op=0; stall high at 11–12; fp_write at 13 with fp_wr_addr=3; stall low at 13.
- div.s f7 then add.s f2 held under stall → fp_write f7 at T+12; add accepted in the WB cycle; fp_start at T+13; fp_write f2 at T+15.
- lwc1 ft=9, then swc1 → fp_mem_read and fp_write with addr 9 at T+1; fp_mem_write at T+2; stall never asserted.
- mul.s in flight, flush at EXEC cycle 2 → IDLE next cycle; no fp_write; a following add.s issues normally.
- rst_n low mid div.s EXEC → all outputs 0 immediately without a clock; no write after release.
- COP1 with fmt=00000 and funct=000111, then fmt=01000 → illegal_fp pulse at T+1 for each; no fp_start, no write.
